// File: rtl/exception_monitor.sv
// Exception and privilege monitor: arbitrates branch-miss, exception vectoring,
// return-from-exception and jump redirects, with sticky per-source pending bits.
module exception_monitor #(
    parameter int unsigned     PC_W       = 16,
    parameter int unsigned     NUM_SRC    = 4,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(16'h0000),
    parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(16'h0100)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              miss,
    input  logic [PC_W-1:0]                                   branch_pc,
    input  logic                                              jump,
    input  logic [PC_W-1:0]                                   new_pc,
    input  logic [PC_W-1:0]                                   cur_pc,
    input  logic [NUM_SRC-1:0]                                exc_req,
    input  logic [NUM_SRC-1:0]                                exc_en,
    input  logic [1:0]                                        mode_set,
    input  logic                                              eret,
    output logic                                              j,
    output logic [PC_W-1:0]                                   j_r,
    output logic                                              store_current,
    output logic [1:0]                                        mode,
    output logic [PC_W-1:0]                                   epc,
    output logic [$clog2((NUM_SRC > 1) ? NUM_SRC : 2)-1:0]    cause,
    output logic [NUM_SRC-1:0]                                exc_pending,
    output logic                                              overflow
);

    localparam int unsigned CW = $clog2((NUM_SRC > 1) ? NUM_SRC : 2);

    // mode encoding is {exception_active, privileged}
    localparam logic [1:0] MODE_RESET = 2'b01;
    localparam logic [1:0] MODE_EXC   = 2'b11;

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [PC_W-1:0]    epc_q, epc_d;
    logic [CW-1:0]      cause_q, cause_d;
    logic [1:0]         mode_q, mode_d;
    logic               spriv_q, spriv_d;
    logic               ovf_q, ovf_d;

    logic [CW-1:0]      idx;
    logic               take;
    logic               eret_go;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] clr_mask;
    logic [PC_W-1:0]    vec_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            mode_q    <= MODE_RESET;
            spriv_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            mode_q    <= mode_d;
            spriv_q   <= spriv_d;
            ovf_q     <= ovf_d;
        end
    end

    // Lowest-numbered pending source wins; descending scan leaves it last.
    always_comb begin
        idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (pending_q[i]) idx = CW'(i);
        end
    end

    assign take     = (|pending_q) && !miss && !mode_q[1];
    assign eret_go  = eret && mode_q[1] && !miss && !take;
    assign req      = exc_req & exc_en;
    assign clr_mask = take ? (NUM_SRC'(1) << idx) : '0;
    assign vec_pc   = VEC_BASE + PC_W'(idx) * VEC_STRIDE;

    // Redirect arbitration, highest priority first.
    always_comb begin
        j             = 1'b0;
        j_r           = '0;
        store_current = 1'b0;
        if (miss) begin
            j   = 1'b1;
            j_r = branch_pc;
        end else if (take) begin
            j             = 1'b1;
            j_r           = vec_pc;
            store_current = 1'b1;
        end else if (eret && mode_q[1]) begin
            j   = 1'b1;
            j_r = epc_q;
        end else if (jump) begin
            j   = 1'b1;
            j_r = new_pc;
        end
    end

    // A new request on the bit being cleared this edge re-pends it without overflow.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | req;
        ovf_d     = ovf_q | (|(req & pending_q & ~clr_mask));
        epc_d     = epc_q;
        cause_d   = cause_q;
        mode_d    = mode_q;
        spriv_d   = spriv_q;
        if (take) begin
            epc_d   = cur_pc;
            cause_d = idx;
            spriv_d = mode_q[0];
            mode_d  = MODE_EXC;
        end else if (eret_go) begin
            mode_d = {1'b0, spriv_q};
        end else begin
            case (mode_set)
                2'b01:   mode_d = 2'b00;
                2'b10:   mode_d = 2'b01;
                2'b11:   mode_d = {1'b0, mode_q[0]};
                default: mode_d = mode_q;
            endcase
        end
    end

    assign mode        = mode_q;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign exc_pending = pending_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_exception_monitor.sv
// Scoreboard bench for exception_monitor: per-cycle redirect expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_exception_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss;
    logic [15:0] branch_pc;
    logic        jump;
    logic [15:0] new_pc;
    logic [15:0] cur_pc;
    logic [3:0]  exc_req;
    logic [3:0]  exc_en;
    logic [1:0]  mode_set;
    logic        eret;
    logic        j;
    logic [15:0] j_r;
    logic        store_current;
    logic [1:0]  mode;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic [3:0]  exc_pending;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        j;
        logic [15:0] jr;
        logic        sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    exception_monitor dut (
        .clk(clk), .rst_n(rst_n), .miss(miss), .branch_pc(branch_pc),
        .jump(jump), .new_pc(new_pc), .cur_pc(cur_pc), .exc_req(exc_req),
        .exc_en(exc_en), .mode_set(mode_set), .eret(eret), .j(j), .j_r(j_r),
        .store_current(store_current), .mode(mode), .epc(epc), .cause(cause),
        .exc_pending(exc_pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Redirect monitor: one queued expectation per driven cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("redir_j", 32'(j), 32'(mon_e.j));
            chk("redir_jr", 32'(j_r), 32'(mon_e.jr));
            chk("redir_sc", 32'(store_current), 32'(mon_e.sc));
        end
    end

    task automatic expect_redir(input logic ej, input logic [15:0] ejr, input logic esc);
        exp_t e;
        e.j  = ej;
        e.jr = ejr;
        e.sc = esc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        miss     = 1'b0;
        jump     = 1'b0;
        eret     = 1'b0;
        exc_req  = 4'b0000;
        mode_set = 2'b00;
        exc_en   = 4'b1111;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] m, input logic [3:0] p);
        chk({tag, "_mode"}, 32'(mode), 32'(m));
        chk({tag, "_pend"}, 32'(exc_pending), 32'(p));
    endtask

    initial begin
        rst_n = 1'b0;
        branch_pc = 16'h0; new_pc = 16'h0; cur_pc = 16'h0;
        idle();
        repeat (2) tick();
        chk_state("rst", 2'b01, 4'b0000);
        chk("rst_epc", 32'(epc), 32'h0);
        chk("rst_cause", 32'(cause), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_j", 32'(j), 32'h0);
        chk("rst_jr", 32'(j_r), 32'h0);
        chk("rst_sc", 32'(store_current), 32'h0);
        rst_n = 1'b1;

        // Single request on source 1
        exc_req = 4'b0010; cur_pc = 16'h1234; expect_redir(0, 16'h0, 0); tick();
        chk_state("t1a", 2'b01, 4'b0010);
        idle(); expect_redir(1, 16'h0100, 1); tick();
        chk_state("t1b", 2'b11, 4'b0000);
        chk("t1_epc", 32'(epc), 32'h1234);
        chk("t1_cause", 32'(cause), 32'h1);
        eret = 1'b1; expect_redir(1, 16'h1234, 0); tick();
        chk_state("t1c", 2'b01, 4'b0000);

        // Two sources at once, taken in priority order across an eret
        idle(); exc_req = 4'b0110; expect_redir(0, 16'h0, 0); tick();
        chk_state("t2a", 2'b01, 4'b0110);
        idle(); cur_pc = 16'h2000; expect_redir(1, 16'h0100, 1); tick();
        chk_state("t2b", 2'b11, 4'b0100);
        chk("t2_epc", 32'(epc), 32'h2000);
        eret = 1'b1; expect_redir(1, 16'h2000, 0); tick();
        chk_state("t2c", 2'b01, 4'b0100);
        idle(); cur_pc = 16'h3000; expect_redir(1, 16'h0200, 1); tick();
        chk_state("t2d", 2'b11, 4'b0000);
        chk("t2_cause", 32'(cause), 32'h2);
        eret = 1'b1; expect_redir(1, 16'h3000, 0); tick();
        chk_state("t2e", 2'b01, 4'b0000);

        // Miss defers a pending exception
        idle(); exc_req = 4'b0001; expect_redir(0, 16'h0, 0); tick();
        idle(); miss = 1'b1; branch_pc = 16'h4444;
        for (int c = 0; c < 3; c++) begin
            expect_redir(1, 16'h4444, 0); tick();
        end
        chk_state("t3a", 2'b01, 4'b0001);
        idle(); cur_pc = 16'h5000; expect_redir(1, 16'h0000, 1); tick();
        chk_state("t3b", 2'b11, 4'b0000);
        chk("t3_epc", 32'(epc), 32'h5000);
        chk("t3_cause", 32'(cause), 32'h0);
        eret = 1'b1; expect_redir(1, 16'h5000, 0); tick();
        chk_state("t3c", 2'b01, 4'b0000);

        // User mode is restored by eret
        idle(); mode_set = 2'b01; expect_redir(0, 16'h0, 0); tick();
        chk_state("t4a", 2'b00, 4'b0000);
        idle(); exc_req = 4'b1000; expect_redir(0, 16'h0, 0); tick();
        idle(); cur_pc = 16'h6000; expect_redir(1, 16'h0300, 1); tick();
        chk_state("t4b", 2'b11, 4'b0000);
        eret = 1'b1; expect_redir(1, 16'h6000, 0); tick();
        chk_state("t4c", 2'b00, 4'b0000);

        // Re-request on the bit being cleared: stays pending, no overflow
        idle(); exc_req = 4'b0001; expect_redir(0, 16'h0, 0); tick();
        exc_req = 4'b0001; cur_pc = 16'h9000; expect_redir(1, 16'h0000, 1); tick();
        chk_state("t5a", 2'b11, 4'b0001);
        chk("t5_ovf", 32'(overflow), 32'h0);
        idle(); eret = 1'b1; expect_redir(1, 16'h9000, 0); tick();
        chk_state("t5b", 2'b00, 4'b0001);
        idle(); cur_pc = 16'h9100; expect_redir(1, 16'h0000, 1); tick();
        eret = 1'b1; expect_redir(1, 16'h9100, 0); tick();
        chk_state("t5c", 2'b00, 4'b0000);

        // Overflow while in handler; eret outranks jump
        idle(); exc_req = 4'b0100; expect_redir(0, 16'h0, 0); tick();
        idle(); cur_pc = 16'h7000; expect_redir(1, 16'h0200, 1); tick();
        exc_req = 4'b1000; expect_redir(0, 16'h0, 0); tick();
        chk("t6_ovf0", 32'(overflow), 32'h0);
        exc_req = 4'b1000; expect_redir(0, 16'h0, 0); tick();
        chk_state("t6a", 2'b11, 4'b1000);
        chk("t6_ovf1", 32'(overflow), 32'h1);
        idle(); eret = 1'b1; jump = 1'b1; new_pc = 16'hBEEF;
        expect_redir(1, 16'h7000, 0); tick();
        chk_state("t6b", 2'b00, 4'b1000);
        idle(); cur_pc = 16'h8000; expect_redir(1, 16'h0300, 1); tick();
        chk("t6_cause", 32'(cause), 32'h3);
        eret = 1'b1; expect_redir(1, 16'h8000, 0); tick();
        chk_state("t6c", 2'b00, 4'b0000);

        // eret outside handler falls through to jump; disabled requests vanish
        idle(); eret = 1'b1; jump = 1'b1; new_pc = 16'h1357;
        expect_redir(1, 16'h1357, 0); tick();
        chk_state("t7a", 2'b00, 4'b0000);
        idle(); exc_en = 4'b0000; exc_req = 4'b1111; jump = 1'b1; new_pc = 16'hA5A5;
        expect_redir(1, 16'hA5A5, 0); tick();
        chk_state("t7b", 2'b00, 4'b0000);
        exc_en = 4'b0000; exc_req = 4'b1111; jump = 1'b0;
        expect_redir(0, 16'h0, 0); tick();
        chk_state("t7c", 2'b00, 4'b0000);

        // Asynchronous reset in the middle of a handler
        idle(); exc_req = 4'b0010; expect_redir(0, 16'h0, 0); tick();
        idle(); cur_pc = 16'hC0DE; expect_redir(1, 16'h0100, 1); tick();
        chk_state("t8a", 2'b11, 4'b0000);
        chk("t8_epc", 32'(epc), 32'hC0DE);
        #2 rst_n = 1'b0;
        #1;
        chk_state("t8b", 2'b01, 4'b0000);
        chk("t8_epc0", 32'(epc), 32'h0);
        chk("t8_ovf0", 32'(overflow), 32'h0);
        chk("t8_j0", 32'(j), 32'h0);
        tick();
        rst_n = 1'b1;

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) tick();
        chk("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_monitor.md
# exception_monitor

Parametrised exception and privilege monitor for the processor front end. It arbitrates the redirect sources: branch-miss recovery, prioritised exception vectoring, return-from-exception and ordinary jumps. Pending exceptions are held in sticky buffers, so a concurrent branch miss or an active handler never drops them. It saves the faulting PC and cause, and tracks the two-bit mode (exception-active, privileged). It sits between the decode/execute fault detectors and the PC-select logic.

## Interface
- PC_W, 16, PC/address width
- NUM_SRC, 4, exception sources; index 0 is highest priority
- VEC_BASE, 16'h0000, handler address for source 0
- VEC_STRIDE, 16'h0100, handler spacing; source i vectors to VEC_BASE + i*VEC_STRIDE, truncated to PC_W
- CW (derived), max(1, clog2(NUM_SRC)), cause width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- miss  in  1  branch mispredict; redirect to branch_pc
- branch_pc  in  PC_W  recovery target
- jump  in  1  ordinary jump request
- new_pc  in  PC_W  jump target
- cur_pc  in  PC_W  PC saved to epc when an exception is taken
- exc_req  in  NUM_SRC  per-source exception request, level-sampled each edge
- exc_en  in  NUM_SRC  per-source enable; a disabled request is discarded, not pended
- mode_set  in  2  01 = user, 10 = privileged, 11 = clear exception bit, 00 = hold
- eret  in  1  return from exception
- j  out  1  redirect valid (combinational)
- j_r  out  PC_W  redirect target (combinational); 0 when j=0
- store_current  out  1  high in the exception-take cycle
- mode  out  2  {exception_active, privileged}
- epc  out  PC_W  saved PC
- cause  out  CW  index of the last taken source
- exc_pending  out  NUM_SRC  sticky pending bits
- overflow  out  1  sticky; a request hit an already-pending source

## Operation
- Reset values: mode=01, pending=0, epc=0, cause=0, overflow=0, saved priv=1.
- Reset-derived combinational outputs: j=0, j_r=0, store_current=0.
- Pend: at each edge, pending[i] <= 1 if exc_req[i] & exc_en[i].
- take = |pending & !miss & !mode[1]; idx = lowest set pending bit.
- Combinational priority, highest first:
  - miss: j=1, j_r=branch_pc.
  - take: j=1, j_r=VEC_BASE+idx*VEC_STRIDE, store_current=1.
  - eret & mode[1]: j=1, j_r=epc.
  - jump: j=1, j_r=new_pc.
  - none of the above: j=0, j_r=0.
- eret with mode[1]=0 is a no-op and falls through to jump.
- On a take edge:
  - clear pending[idx]; epc <= cur_pc; cause <= idx.
  - saved priv <= mode[0]; mode <= 11.
- On an eret edge (eret & mode[1] & !miss & !take): mode <= {0, saved priv}.
- mode_set applies only when the edge is neither a take nor an eret:
  - 01 -> 00
  - 10 -> 01
  - 11 -> {0, mode[0]}
  - 00 -> hold
- While mode[1]=1, requests keep pending and are taken, in priority order, after return.
- Simultaneous set and clear of pending[idx]: set wins; the bit stays 1 and overflow is not set.
- Overflow: an enabled request for a bit already 1 that is not being cleared that edge sets overflow. overflow clears only on reset.
- miss with pending set: the exception is deferred, not lost; it is taken in the first cycle with no miss.

## Timing
- Request sampled at edge k -> pending at k+1 -> j/store_current in the cycle after edge k (1-cycle latency).
- epc, cause and mode update at the edge that ends the take cycle.
- j, j_r and store_current are purely combinational from state and inputs; no registered redirect.
- rst_n assertion mid-handler forces the reset values immediately, asynchronously. Pending and epc are lost.
- Deassertion of rst_n is synchronised externally.

## Test plan
- Reset then exc_req=0010, exc_en=1111, cur_pc=16'h1234: next cycle j=1, j_r=16'h0100, store_current=1. After the edge, epc=16'h1234, cause=1, mode=11.
- exc_req=0110 in one cycle: source 1 is taken first. eret (j_r=epc, mode restored to 01) -> next cycle source 2 is taken with j_r=16'h0200.
- Pending source 0 with miss held 3 cycles: j_r=branch_pc each cycle. The cycle miss drops: j_r=16'h0000, store_current=1.
- In mode 01, mode_set=01 -> mode=00. Exception taken -> 11. eret -> mode=00 and j_r=epc.
- exc_req[3] held 2 cycles while mode[1]=1: overflow=1, pending[3]=1. eret with jump=1 the same cycle: j_r=epc, not new_pc.
- exc_en=0000 with exc_req=1111: no pending, j follows jump/new_pc. rst_n low mid-handler: mode=01, epc=0 immediately.
